// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared definitions for the direct-mapped PLB cache.
//   - command encodings presented on Cmd
//   - FSM state constants
//   - geometry helpers deriving line count from the module parameters
package dm_cache_pkg;

  localparam logic [1:0] CACHE_WRITE       = 2'd0;
  localparam logic [1:0] CACHE_READ        = 2'd1;
  localparam logic [1:0] CACHE_REFILL      = 2'd2;
  localparam logic [1:0] CACHE_INIT_REFILL = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOOKUP = 2'd1;
  localparam state_t ST_STREAM = 2'd2;

  // Number of lines held by the cache.
  function automatic int unsigned cache_lines(input int unsigned data_width,
                                              input int unsigned log_line_size,
                                              input int unsigned capacity);
    return capacity / (data_width << log_line_size);
  endfunction

  // Index field width (lines is a power of two, at least 2).
  function automatic int unsigned cache_log_lines(input int unsigned data_width,
                                                  input int unsigned log_line_size,
                                                  input int unsigned capacity);
    return $clog2(cache_lines(data_width, log_line_size, capacity));
  endfunction

endpackage

// File: rtl/dm_cache_ram.sv
// dm_cache_ram: 1R1W synchronous RAM.
//   clk    : clock
//   we     : write enable, waddr/wdata written at the rising edge
//   raddr  : read address, registered; rdata valid the following cycle
//   rdata  : read data (returns the old word on a same-address collision)
module dm_cache_ram #(
  parameter int unsigned Width    = 8,
  parameter int unsigned AddrBits = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AddrBits-1:0] waddr,
  input  logic [Width-1:0]    wdata,
  input  logic [AddrBits-1:0] raddr,
  output logic [Width-1:0]    rdata
);

  logic [Width-1:0] mem [(1 << AddrBits)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped write-back line cache with a per-line extra tag,
// used as the position-map lookaside buffer. Serves single-word read/write
// lookups and passive line refills (victim streams out while new line
// streams in). Miss handling is owned by the requester.
//
// Ports:
//   Clock, Reset       : clock, synchronous active-high reset
//   Ready              : command can be accepted (Enable && Ready)
//   Enable, Cmd        : command strobe and opcode (write/read/refill/init-refill)
//   AddrIn             : word address (offset bits ignored for refills)
//   DIn                : write data or refill stream word
//   ExtraTagIn         : side tag stored with a refilled line
//   OutValid, Hit      : one-cycle result strobe and hit flag
//   DOut               : looked-up word, or victim word while Evicting
//   RefillDataReady    : DIn consumed this cycle during a refill
//   Evicting           : victim word present on DOut
//   AddrOut            : victim line address (offset bits zero)
//   ExtraTagOut        : victim side tag
//
// Build option: DM_CACHE_INIT_REFILL_EN makes Cmd=11 fill the line with
// zeros without consuming DIn; otherwise Cmd=11 behaves as Cmd=10.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned LogLineSize   = 2,
  parameter int unsigned Capacity      = 512,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned ExtraTagWidth = 8,
  parameter int unsigned WriteLate     = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  output logic                     Ready,
  input  logic                     Enable,
  input  logic [1:0]               Cmd,
  input  logic [AddrWidth-1:0]     AddrIn,
  input  logic [DataWidth-1:0]     DIn,
  input  logic [ExtraTagWidth-1:0] ExtraTagIn,
  output logic                     OutValid,
  output logic                     Hit,
  output logic [DataWidth-1:0]     DOut,
  output logic                     RefillDataReady,
  output logic                     Evicting,
  output logic [AddrWidth-1:0]     AddrOut,
  output logic [ExtraTagWidth-1:0] ExtraTagOut
);

  localparam int unsigned Lines       = cache_lines(DataWidth, LogLineSize, Capacity);
  localparam int unsigned LogLines    = cache_log_lines(DataWidth, LogLineSize, Capacity);
  localparam int unsigned TagWidth    = AddrWidth - LogLineSize - LogLines;
  localparam int unsigned TagRamWidth = TagWidth + ExtraTagWidth;
  localparam int unsigned DataAddr    = LogLines + LogLineSize;

  state_t                   state;
  logic [1:0]               cmd_q;
  logic [LogLines-1:0]      idx_q;
  logic [TagWidth-1:0]      tag_q;
  logic [LogLineSize-1:0]   off_q;
  logic [DataWidth-1:0]     din_q;
  logic [ExtraTagWidth-1:0] xtag_q;
  logic [LogLineSize-1:0]   cnt;
  logic [LogLineSize-1:0]   cnt_next;
  logic [Lines-1:0]         valid;

  logic [LogLines-1:0]      idx_in;
  logic [TagWidth-1:0]      tag_in;
  logic [LogLineSize-1:0]   off_in;

  logic                     data_we;
  logic [DataAddr-1:0]      data_waddr;
  logic [DataAddr-1:0]      data_raddr;
  logic [DataWidth-1:0]     data_wdata;
  logic [DataWidth-1:0]     data_rd;

  logic                     tag_we;
  logic [LogLines-1:0]      tag_raddr;
  logic [TagRamWidth-1:0]   tag_rd;

  logic [TagWidth-1:0]      victim_tag;
  logic [ExtraTagWidth-1:0] victim_xtag;
  logic                     victim_valid;
  logic                     hit_raw;
  logic                     last_word;
  logic                     fill_zero;
  logic                     write_hit;
  logic [DataWidth-1:0]     write_word;
  logic                     in_lookup;
  logic                     in_stream;

  assign idx_in = AddrIn[LogLineSize +: LogLines];
  assign tag_in = AddrIn[AddrWidth-1 -: TagWidth];
  assign off_in = AddrIn[LogLineSize-1:0];

  assign cnt_next  = cnt + 1'b1;
  assign last_word = &cnt;

`ifdef DM_CACHE_INIT_REFILL_EN
  assign fill_zero = (cmd_q == CACHE_INIT_REFILL);
`else
  assign fill_zero = 1'b0;
`endif

  generate
    if (WriteLate != 0) begin : g_write_late
      assign write_word = DIn;
    end else begin : g_write_early
      assign write_word = din_q;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ST_IDLE;
      valid  <= '0;
      cnt    <= '0;
      cmd_q  <= '0;
      idx_q  <= '0;
      tag_q  <= '0;
      off_q  <= '0;
      din_q  <= '0;
      xtag_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Enable) begin
            cmd_q  <= Cmd;
            idx_q  <= idx_in;
            tag_q  <= tag_in;
            off_q  <= off_in;
            din_q  <= DIn;
            xtag_q <= ExtraTagIn;
            cnt    <= '0;
            state  <= Cmd[1] ? ST_STREAM : ST_LOOKUP;
          end
        end
        ST_LOOKUP: state <= ST_IDLE;
        ST_STREAM: begin
          cnt <= cnt_next;
          if (last_word) begin
            valid[idx_q] <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign victim_tag   = tag_rd[TagRamWidth-1 -: TagWidth];
  assign victim_xtag  = tag_rd[ExtraTagWidth-1:0];
  assign victim_valid = valid[idx_q];
  assign hit_raw      = victim_valid && (victim_tag == tag_q);
  assign in_lookup    = !Reset && (state == ST_LOOKUP);
  assign in_stream    = !Reset && (state == ST_STREAM);
  assign write_hit    = in_lookup && (cmd_q == CACHE_WRITE) && hit_raw;

  // Synchronous-read arrays: the address is issued one cycle ahead of use.
  // While streaming, word cnt+1 is fetched while word cnt is overwritten,
  // so each victim word is read out before its slot is replaced.
  always_comb begin
    data_raddr = {idx_q, off_q};
    tag_raddr  = idx_q;
    if (state == ST_IDLE) begin
      data_raddr = {idx_in, (Cmd[1] ? {LogLineSize{1'b0}} : off_in)};
      tag_raddr  = idx_in;
    end else if (state == ST_STREAM) begin
      data_raddr = {idx_q, cnt_next};
    end
  end

  always_comb begin
    data_we    = 1'b0;
    data_waddr = {idx_q, off_q};
    data_wdata = write_word;
    if (write_hit) begin
      data_we = 1'b1;
    end else if (in_stream) begin
      data_we    = 1'b1;
      data_waddr = {idx_q, cnt};
      data_wdata = fill_zero ? '0 : DIn;
    end
  end

  assign tag_we = in_stream && last_word;

  dm_cache_ram #(
    .Width    (DataWidth),
    .AddrBits (DataAddr)
  ) u_data_ram (
    .clk   (Clock),
    .we    (data_we),
    .waddr (data_waddr),
    .wdata (data_wdata),
    .raddr (data_raddr),
    .rdata (data_rd)
  );

  dm_cache_ram #(
    .Width    (TagRamWidth),
    .AddrBits (LogLines)
  ) u_tag_ram (
    .clk   (Clock),
    .we    (tag_we),
    .waddr (idx_q),
    .wdata ({tag_q, xtag_q}),
    .raddr (tag_raddr),
    .rdata (tag_rd)
  );

  // Outputs are forced to their idle values while Reset is asserted.
  assign Ready           = Reset || (state == ST_IDLE);
  assign OutValid        = in_lookup || (in_stream && last_word);
  assign Hit             = in_lookup && hit_raw;
  assign Evicting        = in_stream && victim_valid;
  assign RefillDataReady = in_stream && !fill_zero;
  assign DOut            = (in_lookup || Evicting) ? data_rd : '0;
  assign AddrOut         = in_stream ? {victim_tag, idx_q, {LogLineSize{1'b0}}} : '0;
  assign ExtraTagOut     = in_stream ? victim_xtag : '0;

endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: scoreboard bench for dm_cache. Two instances share stimulus:
// u_dut0 with WriteLate=0 and u_dut1 with WriteLate=1; each gets its own DIn
// so that only the correctly timed sample carries the real write data.
module tb_dm_cache;
  import dm_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  cmd;
  logic [15:0] addr;
  logic [31:0] din0, din1;
  logic [7:0]  xtag;

  logic        ready0, ov0, hit0, rdr0, ev0;
  logic [31:0] dout0;
  logic [15:0] aout0;
  logic [7:0]  xout0;
  logic        ready1, ov1, hit1, rdr1, ev1;
  logic [31:0] dout1;
  logic [15:0] aout1;
  logic [7:0]  xout1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        hit;
    logic [31:0] dout;
    logic        chk;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] eq0[$], eq1[$];

  always #5 clk = ~clk;

  dm_cache u_dut0 (
    .Clock(clk), .Reset(rst), .Ready(ready0), .Enable(en), .Cmd(cmd),
    .AddrIn(addr), .DIn(din0), .ExtraTagIn(xtag), .OutValid(ov0), .Hit(hit0),
    .DOut(dout0), .RefillDataReady(rdr0), .Evicting(ev0), .AddrOut(aout0),
    .ExtraTagOut(xout0)
  );

  dm_cache #(.WriteLate(1)) u_dut1 (
    .Clock(clk), .Reset(rst), .Ready(ready1), .Enable(en), .Cmd(cmd),
    .AddrIn(addr), .DIn(din1), .ExtraTagIn(xtag), .OutValid(ov1), .Hit(hit1),
    .DOut(dout1), .RefillDataReady(rdr1), .Evicting(ev1), .AddrOut(aout1),
    .ExtraTagOut(xout1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic h, input logic [31:0] d, input logic c);
    exp_t e;
    e.hit = h; e.dout = d; e.chk = c;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Result and eviction monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov0) begin
        if (q0.size() == 0) check_eq("ov0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check_eq("hit0", hit0, e.hit);
          if (e.chk) check_eq("dout0", dout0, e.dout);
        end
      end
      if (ov1) begin
        if (q1.size() == 0) check_eq("ov1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check_eq("hit1", hit1, e.hit);
          if (e.chk) check_eq("dout1", dout1, e.dout);
        end
      end
      if (ev0) begin
        if (eq0.size() == 0) check_eq("ev0_unexpected", 1, 0);
        else check_eq("evict_word0", dout0, eq0.pop_front());
      end
      if (ev1) begin
        if (eq1.size() == 0) check_eq("ev1_unexpected", 1, 0);
        else check_eq("evict_word1", dout1, eq1.pop_front());
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, {ready0, ready1}, 2'b11);
    check_eq({tag, "_flags"}, {ov0, hit0, ev0, rdr0, ov1, hit1, ev1, rdr1}, 8'h00);
    check_eq({tag, "_data"}, {dout0, aout0, xout0}, 56'h0);
    check_eq({tag, "_data1"}, {dout1, aout1, xout1}, 56'h0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready0 && ready1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_wait", {ready0, ready1}, 2'b11);
  endtask

  // Read/write lookup. d_early goes to u_dut0 at T, d_late to u_dut1 at T+1;
  // the other instance sees inverted garbage in the same cycle.
  task automatic lookup(input logic [1:0] c, input logic [15:0] a,
                        input logic [31:0] d_early, input logic [31:0] d_late,
                        input logic eh, input logic [31:0] ed, input logic chk);
    wait_ready();
    en = 1'b1; cmd = c; addr = a;
    din0 = d_early; din1 = ~d_early;
    push_exp(eh, ed, chk);
    @(posedge clk); #1;
    en = 1'b0; din0 = ~d_late; din1 = d_late;
    @(negedge clk);
    check_eq("busy_lookup", {ready0, ready1}, 2'b00);
    @(posedge clk); #1;
    check_eq("ready_after_lookup", {ready0, ready1}, 2'b11);
  endtask

  task automatic refill(input logic [1:0] c, input logic [15:0] a, input logic [7:0] xt,
                        input logic [31:0] base, input logic exp_rdr, input logic ev,
                        input logic [15:0] eaddr, input logic [7:0] ext,
                        input logic [3:0][31:0] ew);
    wait_ready();
    en = 1'b1; cmd = c; addr = a; xtag = xt;
    push_exp(1'b0, 32'h0, 1'b0);
    if (ev) begin
      for (int i = 0; i < 4; i++) begin
        eq0.push_back(ew[i]);
        eq1.push_back(ew[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      en = 1'b0; din0 = base + 32'(i); din1 = base + 32'(i);
      @(negedge clk);
      check_eq("refill_busy", {ready0, ready1}, 2'b00);
      check_eq("refill_rdr", {rdr0, rdr1}, {exp_rdr, exp_rdr});
      check_eq("refill_evicting", {ev0, ev1}, {ev, ev});
      check_eq("refill_ov_timing", ov0, (i == 3));
      if (ev) begin
        check_eq("victim_addr", aout0, eaddr);
        check_eq("victim_xtag", xout0, ext);
      end
    end
    @(posedge clk); #1;
    check_eq("refill_done_ready", {ready0, ready1}, 2'b11);
    check_eq("refill_done_rdr", rdr0, 1'b0);
  endtask

  logic        exp_init_rdr;
  logic [31:0] init_word1;

  initial begin
`ifdef DM_CACHE_INIT_REFILL_EN
    exp_init_rdr = 1'b0;
    init_word1   = 32'h0;
`else
    exp_init_rdr = 1'b1;
    init_word1   = 32'hD1;
`endif
    rst = 1'b1; en = 1'b0; cmd = '0; addr = '0; din0 = '0; din1 = '0; xtag = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("under_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
    @(posedge clk); #1;

    // Cold miss.
    lookup(CACHE_READ, 16'h0010, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Fill line 0 (tag 1) from an empty slot.
    refill(CACHE_REFILL, 16'h0010, 8'h5A, 32'hA0, 1'b1, 1'b0, 16'h0, 8'h0, '0);
    lookup(CACHE_READ, 16'h0012, 32'h0, 32'h0, 1'b1, 32'hA2, 1'b1);
    lookup(CACHE_READ, 16'h0010, 32'h0, 32'h0, 1'b1, 32'hA0, 1'b1);

    // Write hit returns the old word; each instance must take its own DIn timing.
    lookup(CACHE_WRITE, 16'h0013, 32'h77, 32'h77, 1'b1, 32'hA3, 1'b1);
    lookup(CACHE_READ, 16'h0013, 32'h0, 32'h0, 1'b1, 32'h77, 1'b1);

    // Conflict refill (offset bits set, must be ignored) evicts line 0.
    refill(CACHE_REFILL, 16'h0052, 8'hC3, 32'hB0, 1'b1, 1'b1, 16'h0010, 8'h5A,
           {32'h77, 32'hA2, 32'hA1, 32'hA0});
    lookup(CACHE_READ, 16'h0051, 32'h0, 32'h0, 1'b1, 32'hB1, 1'b1);
    lookup(CACHE_READ, 16'h0010, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Write miss changes nothing.
    lookup(CACHE_WRITE, 16'h0014, 32'h99, 32'h99, 1'b0, 32'h0, 1'b0);
    lookup(CACHE_READ, 16'h0014, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Init-refill into line 1.
    refill(CACHE_INIT_REFILL, 16'h0014, 8'h11, 32'hD0, exp_init_rdr, 1'b0, 16'h0, 8'h0, '0);
    lookup(CACHE_READ, 16'h0015, 32'h0, 32'h0, 1'b1, init_word1, 1'b1);

    // Reset in the second cycle of an evicting refill of line 0.
    wait_ready();
    en = 1'b1; cmd = CACHE_REFILL; addr = 16'h0090; xtag = 8'h22;
    eq0.push_back(32'hB0);
    eq1.push_back(32'hB0);
    @(posedge clk); #1;
    en = 1'b0; din0 = 32'hC0; din1 = 32'hC0;
    @(negedge clk);
    check_eq("abort_stream_rdr", {rdr0, rdr1}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_abort");
    @(posedge clk); #1;
    lookup(CACHE_READ, 16'h0050, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    lookup(CACHE_READ, 16'h0015, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("result_queue_drained", q0.size() + q1.size(), 0);
    check_eq("evict_queue_drained", eq0.size() + eq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
